br_predict_unit: RTL and testbench
==================================

# br_predict_unit

Dynamic branch predictor and resolver for the pipelined MIPS core. Holds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. The IF stage looks up its PC every cycle and gets a predicted next-PC. When a branch or jump resolves in ID, the block flags a misprediction, supplies the redirect PC, trains the table and counts branch and misprediction events.

## Interface
Parameters:
- ENTRIES, 64: BTB depth; power of two, ≥ 2; IDX_W = log2(ENTRIES).
- TAG_W, 8: stored tag width; IDX_W + TAG_W + 2 ≤ 32.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- if_pc  in  32  PC being fetched.
- pred_taken  out  1  predicted taken for if_pc.
- pred_target  out  32  predicted next PC (target if taken, else if_pc+4).
- res_valid  in  1  an instruction resolves this cycle.
- res_pc  in  32  PC of the resolving instruction.
- res_is_branch  in  1  instruction is a branch, J/JAL or JR/JALR.
- res_uncond  in  1  J/JAL/JR/JALR (always taken).
- res_taken  in  1  actual direction (ignored unless res_is_branch).
- res_target  in  32  actual target.
- res_pred_taken  in  1  pred_taken carried down the pipe with the instruction.
- res_pred_target  in  32  pred_target carried down the pipe.
- mispredict  out  1  the resolving instruction was mispredicted; IF/ID must flush.
- redirect_pc  out  32  correct next PC when mispredict = 1.
- br_count  out  CNT_W  resolved branches.
- miss_count  out  CNT_W  mispredictions.

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Each entry holds valid, tag, target[31:0] and ctr[1:0].
- Lookup is combinational: hit = valid && tag match. pred_taken = hit && ctr[1]. pred_target = pred_taken ? target : if_pc+4 (mod 2^32).
- Actual direction: act_taken = res_is_branch && (res_taken || res_uncond). act_next = act_taken ? res_target : res_pc+4.
- mispredict = res_valid && (res_pred_taken != act_taken || (act_taken && res_pred_target != res_target)).
- redirect_pc = act_next. Both mispredict and redirect_pc are combinational from the res_* inputs.
- Training, on a clock edge with res_valid = 1, where "hit" is the lookup of res_pc:
  - Branch and hit: ctr increments when taken and decrements otherwise, saturating at 3 and 0. When taken, target ← res_target. When res_uncond, ctr ← 3.
  - Branch, miss, taken: allocate (overwrite) with valid = 1, tag, target = res_target, ctr = 3 if res_uncond else 2.
  - Branch, miss, not taken: no write.
  - Not a branch and hit (aliasing): valid ← 0.
- Statistics:
  - br_count increments when res_valid && res_is_branch.
  - miss_count increments when mispredict.
  - Both saturate at 2^CNT_W−1 and never wrap.

## Timing
- Reset: all valid bits cleared, all ctr = 2'b01, targets and tags cleared, br_count = miss_count = 0.
- The combinational outputs then follow their inputs: pred_taken = 0 and pred_target = if_pc+4 for any if_pc.
- Prediction latency is 0 cycles (same-cycle lookup). A training write is visible to lookups from the next cycle.
- Lookup and training on the same index in the same cycle: the lookup returns the pre-update contents; there is no bypass.
- Reset asserted mid-operation wins over any concurrent training or count increment; the state is reset values on the next cycle.
- res_valid = 0: no table write, no count change, mispredict = 0.

## Test plan
- Reset, then if_pc = 0x0040_0010 → pred_taken = 0, pred_target = 0x0040_0014; both counts 0.
- Taken BEQ resolves at pc 0x0040_0020 with target 0x0040_0100 and res_pred_taken = 0 → mispredict = 1, redirect_pc = 0x0040_0100, miss_count = 1. On the next cycle, lookup of 0x0040_0020 → pred_taken = 1, pred_target = 0x0040_0100.
- Same branch then resolves not-taken twice with correct predictions supplied on the res_pred_* inputs → ctr goes 2→1→0. The first resolve flags mispredict with redirect_pc = 0x0040_0024; the lookup then predicts not-taken.
- JAL allocated with ctr = 3; 5 subsequent correct resolves → no mispredict, br_count increments by 5, ctr stays 3.
- Aliasing: a non-branch at the same index and tag as a valid entry resolves → entry invalidated. If res_pred_taken = 1, mispredict = 1 and redirect_pc = res_pc+4.
- Same-cycle update and lookup on one index → lookup shows the old entry; reset asserted during a resolve → all state cleared, counts 0.

Source files
------------

// File: rtl/br_predict_unit_if.sv
// rtl/br_predict_unit_if.sv - fetch lookup, resolve and statistics bundle for br_predict_unit
interface br_predict_unit_if #(parameter int CNT_W = 32);
    logic [31:0]      if_pc;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             res_valid;
    logic [31:0]      res_pc;
    logic             res_is_branch;
    logic             res_uncond;
    logic             res_taken;
    logic [31:0]      res_target;
    logic             res_pred_taken;
    logic [31:0]      res_pred_target;
    logic             mispredict;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] miss_count;

    modport master (
        output if_pc, res_valid, res_pc, res_is_branch, res_uncond, res_taken,
               res_target, res_pred_taken, res_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc, br_count, miss_count
    );

    modport slave (
        input  if_pc, res_valid, res_pc, res_is_branch, res_uncond, res_taken,
               res_target, res_pred_taken, res_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc, br_count, miss_count
    );
endinterface

// File: rtl/br_predict_unit.sv
// rtl/br_predict_unit.sv - direct-mapped BTB with 2-bit counters, branch resolve and event counters
module br_predict_unit #(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 32
) (
    input logic             clk,
    input logic             rst,
    br_predict_unit_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid_mem;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [31:0]        tgt_mem [ENTRIES];
    logic [1:0]         ctr_mem [ENTRIES];
    logic [CNT_W-1:0]   br_cnt;
    logic [CNT_W-1:0]   miss_cnt;

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             r_hit;
    logic             act_taken;
    logic [31:0]      act_next;
    logic             miss;
    logic             unused_pc;

    assign unused_pc = ^{bp.if_pc, bp.res_pc};

    assign f_idx = bp.if_pc[IDX_W+1:2];
    assign f_tag = bp.if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign r_idx = bp.res_pc[IDX_W+1:2];
    assign r_tag = bp.res_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Fetch lookup reads the stored state directly, so a same-cycle write is not visible yet.
    assign f_hit          = valid_mem[f_idx] && (tag_mem[f_idx] == f_tag);
    assign bp.pred_taken  = f_hit && ctr_mem[f_idx][1];
    assign bp.pred_target = bp.pred_taken ? tgt_mem[f_idx] : bp.if_pc + 32'd4;

    assign r_hit     = valid_mem[r_idx] && (tag_mem[r_idx] == r_tag);
    assign act_taken = bp.res_is_branch && (bp.res_taken || bp.res_uncond);
    assign act_next  = act_taken ? bp.res_target : bp.res_pc + 32'd4;
    assign miss      = bp.res_valid &&
                       ((bp.res_pred_taken != act_taken) ||
                        (act_taken && (bp.res_pred_target != bp.res_target)));

    assign bp.mispredict  = miss;
    assign bp.redirect_pc = act_next;
    assign bp.br_count    = br_cnt;
    assign bp.miss_count  = miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_mem <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_mem[i] <= '0;
                tgt_mem[i] <= '0;
                ctr_mem[i] <= 2'b01;
            end
            br_cnt   <= '0;
            miss_cnt <= '0;
        end else if (bp.res_valid) begin
            if (bp.res_is_branch) begin
                if (r_hit) begin
                    if (bp.res_uncond)
                        ctr_mem[r_idx] <= 2'b11;
                    else if (act_taken)
                        ctr_mem[r_idx] <= (ctr_mem[r_idx] == 2'b11) ? 2'b11 : ctr_mem[r_idx] + 2'd1;
                    else
                        ctr_mem[r_idx] <= (ctr_mem[r_idx] == 2'b00) ? 2'b00 : ctr_mem[r_idx] - 2'd1;
                    if (act_taken)
                        tgt_mem[r_idx] <= bp.res_target;
                end else if (act_taken) begin
                    valid_mem[r_idx] <= 1'b1;
                    tag_mem[r_idx]   <= r_tag;
                    tgt_mem[r_idx]   <= bp.res_target;
                    ctr_mem[r_idx]   <= bp.res_uncond ? 2'b11 : 2'b10;
                end
                if (br_cnt != {CNT_W{1'b1}})
                    br_cnt <= br_cnt + 1'b1;
            end else if (r_hit) begin
                // A non-branch matching an entry means the entry aliases; drop it.
                valid_mem[r_idx] <= 1'b0;
            end
            if (miss && (miss_cnt != {CNT_W{1'b1}}))
                miss_cnt <= miss_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_br_predict_unit.sv
// tb/tb_br_predict_unit.sv - scoreboard bench for br_predict_unit
module tb_br_predict_unit;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    br_predict_unit_if #(.CNT_W(CNT_W)) bus ();

    br_predict_unit #(.ENTRIES(64), .TAG_W(8), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bus.slave)
    );

    typedef struct {
        string       tag;
        logic        pt;
        logic [31:0] ptg;
        logic        mp;
        logic [31:0] rpc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_bc = 0;
    logic [31:0] m_mc = 0;
    localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 1;

    localparam logic [31:0] A  = 32'h0040_0020;
    localparam logic [31:0] T  = 32'h0040_0100;
    localparam logic [31:0] J  = 32'h0040_0200;
    localparam logic [31:0] JT = 32'h0040_1000;
    localparam logic [31:0] B  = 32'h0040_0044;
    localparam logic [31:0] BT = 32'h0040_0400;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [31:0] fpc,
                        input logic rv, input logic [31:0] rpc, input logic isbr, input logic unc,
                        input logic tkn, input logic [31:0] tgt, input logic rpt, input logic [31:0] rptg,
                        input logic e_pt, input logic [31:0] e_ptg, input logic e_mp, input logic [31:0] e_rpc);
        exp_t e;
        @(negedge clk);
        rst                 = r;
        bus.if_pc           = fpc;
        bus.res_valid       = rv;
        bus.res_pc          = rpc;
        bus.res_is_branch   = isbr;
        bus.res_uncond      = unc;
        bus.res_taken       = tkn;
        bus.res_target      = tgt;
        bus.res_pred_taken  = rpt;
        bus.res_pred_target = rptg;
        e = '{tag, e_pt, e_ptg, e_mp, e_rpc, m_bc, m_mc};
        sb.push_back(e);
        #1;
        if (sb.size() == 0) begin
            check_value({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_value({e.tag, ".pred_taken"},  {31'd0, bus.pred_taken}, {31'd0, e.pt});
            check_value({e.tag, ".pred_target"}, bus.pred_target,          e.ptg);
            check_value({e.tag, ".mispredict"},  {31'd0, bus.mispredict}, {31'd0, e.mp});
            check_value({e.tag, ".redirect_pc"}, bus.redirect_pc,          e.rpc);
            check_value({e.tag, ".br_count"},    32'(bus.br_count),        e.bc);
            check_value({e.tag, ".miss_count"},  32'(bus.miss_count),      e.mc);
        end
        if (r) begin
            m_bc = 0;
            m_mc = 0;
        end else begin
            if (rv && isbr && m_bc != CNT_MAX) m_bc++;
            if (e_mp && m_mc != CNT_MAX)       m_mc++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.if_pc = '0; bus.res_valid = 1'b0; bus.res_pc = '0; bus.res_is_branch = 1'b0;
        bus.res_uncond = 1'b0; bus.res_taken = 1'b0; bus.res_target = '0;
        bus.res_pred_taken = 1'b0; bus.res_pred_target = '0;
        repeat (2) @(posedge clk);

        step("reset", 0, 32'h0040_0010, 0, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0040_0014, 0, 32'd4);
        step("beq_alloc", 0, A, 1, A, 1, 0, 1, T, 0, A + 4,      0, A + 4, 1, T);
        step("beq_hit", 0, A, 0, 0, 0, 0, 0, 0, 0, 0,            1, T, 0, 32'd4);
        step("nt1", 0, A, 1, A, 1, 0, 0, T, 1, T,                1, T, 1, A + 4);
        step("nt2", 0, A, 1, A, 1, 0, 0, T, 0, A + 4,            0, A + 4, 0, A + 4);
        step("nt_pred", 0, A, 0, 0, 0, 0, 0, 0, 0, 0,            0, A + 4, 0, 32'd4);

        step("jal_alloc", 0, J, 1, J, 1, 1, 0, JT, 0, J + 4,     0, J + 4, 1, JT);
        for (int i = 0; i < 5; i++)
            step($sformatf("jal_rep%0d", i), 0, J, 1, J, 1, 1, 0, JT, 1, JT, 1, JT, 0, JT);
        // Counter 3 drops to 2 and still predicts taken; had it been 2 it would flip.
        step("jal_ctr3", 0, J, 1, J, 1, 0, 0, JT, 1, JT,         1, JT, 1, J + 4);
        step("jal_ctr2", 0, J, 0, 0, 0, 0, 0, 0, 0, 0,           1, JT, 0, 32'd4);

        step("alias", 0, J, 1, J, 0, 0, 1, 32'h1234_5678, 1, JT, 1, JT, 1, J + 4);
        step("alias_inv", 0, J, 0, 0, 0, 0, 0, 0, 0, 0,          0, J + 4, 0, 32'd4);

        step("same_cyc", 0, B, 1, B, 1, 0, 1, BT, 0, B + 4,      0, B + 4, 1, BT);
        step("same_next", 0, B, 0, 0, 0, 0, 0, 0, 0, 0,          1, BT, 0, 32'd4);

        for (int i = 0; i < 10; i++)
            step($sformatf("sat%0d", i), 0, B, 1, B, 1, 0, 1, BT, 0, B + 4, 1, BT, 1, BT);
        step("sat_hold", 0, B, 0, 0, 0, 0, 0, 0, 0, 0,           1, BT, 0, 32'd4);
        step("wrap", 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0,   0, 32'h0000_0000, 0, 32'd4);

        step("rst_mid", 1, B, 1, B, 1, 0, 1, BT, 0, B + 4,       1, BT, 1, BT);
        step("post_rst", 0, B, 0, 0, 0, 0, 0, 0, 0, 0,           0, B + 4, 0, 32'd4);
        step("post_rst_a", 0, A, 0, 0, 0, 0, 0, 0, 0, 0,         0, A + 4, 0, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
